regfile_2r1w_param: RTL and testbench

//  Parametrised register file: one write port, two read ports.

---
 rtl/regfile_2r1w_param.sv | 160 ++++++++++++++++
 tb/tb_regfile_2r1w_param.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w_param.sv
// Parametrised 2-read / 1-write register file with registered reads,
// optional write-to-read forwarding, optional hard-wired zero entry and a
// sequenced soft-clear engine that sweeps every entry to zero.
module regfile_2r1w_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr1,
  input  logic [ADDR_WIDTH-1:0] rd_addr2,
  output logic [DATA_WIDTH-1:0] rd_data1,
  output logic [DATA_WIDTH-1:0] rd_data2,
  input  logic                  clr_start,
  output logic                  busy
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(32'd1);
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic ZERO_EN   = (ZERO_REG != 32'sd0);
  localparam logic BYPASS_EN = (BYPASS != 32'sd0);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  busy_q, busy_d;
  logic [DATA_WIDTH-1:0] rd_data1_q, rd_data1_d;
  logic [DATA_WIDTH-1:0] rd_data2_q, rd_data2_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic                  wr_acc;

  // Read-port data selection: hard-wired zero, then forwarded write, then storage.
  // The soft clear is deliberately never forwarded; a read of the entry being
  // cleared on the same edge sees the stored (old) value.
  function automatic logic [DATA_WIDTH-1:0] read_sel(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic                  acc,
    input logic [ADDR_WIDTH-1:0] waddr,
    input logic [DATA_WIDTH-1:0] wdata,
    input logic [DATA_WIDTH-1:0] stored
  );
    logic [DATA_WIDTH-1:0] res;
    if (ZERO_EN && (addr == ADDR_ZERO)) begin
      res = DATA_ZERO;
    end else if (BYPASS_EN && acc && (waddr == addr)) begin
      res = wdata;
    end else begin
      res = stored;
    end
    return res;
  endfunction

  // Write acceptance: no writes while sweeping, none to the hard-wired zero entry.
  always_comb begin
    wr_acc = wr_en && !busy_q && !(ZERO_EN && (wr_addr == ADDR_ZERO));
  end

  // Soft-clear sequencer: next state, sweep pointer and busy flag.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d = ST_CLEAR;
          ptr_d   = ADDR_ZERO;
          busy_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_CLEAR: begin
        // Pointer wraps to zero naturally after the last entry.
        ptr_d = ptr_q + ADDR_ONE;
        if (ptr_q == ADDR_LAST) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_CLEAR;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = ADDR_ZERO;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Storage next value: sweep clear or accepted write, otherwise hold.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      if ((state_q == ST_CLEAR) && (ptr_q == ADDR_WIDTH'(i))) begin
        mem_d[i] = DATA_ZERO;
      end else if (wr_acc && (wr_addr == ADDR_WIDTH'(i))) begin
        mem_d[i] = wr_data;
      end else begin
        mem_d[i] = mem_q[i];
      end
    end
  end

  // Read ports: capture selected data when rd_en is high, otherwise hold.
  always_comb begin
    rd_data1_d = rd_data1_q;
    rd_data2_d = rd_data2_q;
    if (rd_en) begin
      rd_data1_d = read_sel(rd_addr1, wr_acc, wr_addr, wr_data, mem_q[rd_addr1]);
      rd_data2_d = read_sel(rd_addr2, wr_acc, wr_addr, wr_data, mem_q[rd_addr2]);
    end else begin
      rd_data1_d = rd_data1_q;
      rd_data2_d = rd_data2_q;
    end
  end

  // State, storage and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= ADDR_ZERO;
      busy_q     <= 1'b0;
      rd_data1_q <= DATA_ZERO;
      rd_data2_q <= DATA_ZERO;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= DATA_ZERO;
      end
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      busy_q     <= busy_d;
      rd_data1_q <= rd_data1_d;
      rd_data2_q <= rd_data2_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign rd_data1 = rd_data1_q;
  assign rd_data2 = rd_data2_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_regfile_2r1w_param.sv
// Self-checking bench for regfile_2r1w_param: directed scenarios plus a
// randomized run, all compared against a behavioural model of the file.
module tb_regfile_2r1w_param;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int ZR    = 1;
  localparam int BP    = 1;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [AW-1:0] rd_addr1;
  logic [AW-1:0] rd_addr2;
  logic [DW-1:0] rd_data1;
  logic [DW-1:0] rd_data2;
  logic          clr_start;
  logic          busy;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: array of words, remaining sweep cycles, sweep index.
  logic [DW-1:0] mdl_mem [DEPTH];
  int            mdl_clear_left = 0;
  int            mdl_ptr = 0;
  logic [DW-1:0] exp_rd1 = '0;
  logic [DW-1:0] exp_rd2 = '0;
  logic          exp_busy = 1'b0;

  regfile_2r1w_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ZERO_REG(ZR), .BYPASS(BP)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .clr_start(clr_start), .busy(busy)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, advance the model across the edge, return #1 after it.
  task automatic step(input logic r, input logic we, input logic [AW-1:0] wa,
                      input logic [DW-1:0] wd, input logic re,
                      input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                      input logic cl);
    bit is_busy, acc;
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_en = re; rd_addr1 = a1; rd_addr2 = a2; clr_start = cl;
    is_busy = (mdl_clear_left > 0);
    acc = we && !is_busy && !(ZR != 0 && wa == 0);
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
      mdl_clear_left = 0; mdl_ptr = 0; exp_rd1 = '0; exp_rd2 = '0;
    end else begin
      if (re) begin
        if (ZR != 0 && a1 == 0) exp_rd1 = '0;
        else if (BP != 0 && acc && wa == a1) exp_rd1 = wd;
        else exp_rd1 = mdl_mem[a1];
        if (ZR != 0 && a2 == 0) exp_rd2 = '0;
        else if (BP != 0 && acc && wa == a2) exp_rd2 = wd;
        else exp_rd2 = mdl_mem[a2];
      end
      if (acc) mdl_mem[wa] = wd;
      if (is_busy) begin
        mdl_mem[mdl_ptr] = '0;
        mdl_ptr = mdl_ptr + 1;
        mdl_clear_left = mdl_clear_left - 1;
      end else if (cl) begin
        mdl_clear_left = DEPTH;
        mdl_ptr = 0;
      end
    end
    exp_busy = (mdl_clear_left > 0);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 5'd3, 32'hFFFF_FFFF, 1'b1, 5'd3, 5'd31, 1'b1);
    step(1'b0, 1'b0, '0, '0, 1'b1, 5'd3, 5'd31, 1'b0);
    vectors++;
    if (rd_data1 !== 32'h0) begin
      miscompares++; $display("FAIL reset_rd1 got %h want %h", rd_data1, 32'h0);
    end
    vectors++;
    if (rd_data2 !== 32'h0) begin
      miscompares++; $display("FAIL reset_rd2 got %h want %h", rd_data2, 32'h0);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy got %b want 0", busy);
    end
  endtask

  task automatic test_write_read();
    step(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 5'd5, 5'd6, 1'b0);
    vectors++;
    if (rd_data1 !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL write_read got %h want %h", rd_data1, 32'hDEAD_BEEF);
    end
    step(1'b0, 1'b1, 5'd5, 32'h0BAD_F00D, 1'b0, 5'd9, 5'd9, 1'b0);
    idle();
    vectors++;
    if (rd_data1 !== 32'hDEAD_BEEF) begin
      miscompares++; $display("FAIL read_hold got %h want %h", rd_data1, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] want;
    step(1'b0, 1'b1, 5'd7, 32'h0000_0055, 1'b0, '0, '0, 1'b0);
    step(1'b0, 1'b1, 5'd7, 32'h0000_1234, 1'b1, 5'd7, 5'd8, 1'b0);
    want = (BP != 0) ? 32'h0000_1234 : 32'h0000_0055;
    vectors++;
    if (rd_data1 !== want) begin
      miscompares++; $display("FAIL bypass got %h want %h", rd_data1, want);
    end
    step(1'b0, 1'b0, '0, '0, 1'b1, 5'd7, 5'd7, 1'b0);
    vectors++;
    if (rd_data2 !== 32'h0000_1234) begin
      miscompares++; $display("FAIL after_bypass got %h want %h", rd_data2, 32'h0000_1234);
    end
  endtask

  task automatic test_zero_reg();
    logic [DW-1:0] want;
    step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 5'd0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 5'd0, 1'b0);
    want = (ZR != 0) ? 32'h0 : 32'hFFFF_FFFF;
    vectors++;
    if (rd_data1 !== want || rd_data2 !== want) begin
      miscompares++;
      $display("FAIL zero_reg got %h/%h want %h", rd_data1, rd_data2, want);
    end
  endtask

  task automatic test_clear();
    int busy_cycles;
    for (int i = 0; i < DEPTH; i++)
      step(1'b0, 1'b1, AW'(i), DW'(i + 1), 1'b0, '0, '0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 5'd9, 5'd31, 1'b1);
    vectors++;
    if (rd_data1 !== 32'd10 || rd_data2 !== 32'd32) begin
      miscompares++;
      $display("FAIL fill_read got %h/%h want %h/%h", rd_data1, rd_data2, 32'd10, 32'd32);
    end
    busy_cycles = 0;
    while (busy === 1'b1 && busy_cycles < 100) begin
      busy_cycles++;
      if (busy_cycles == 3) step(1'b0, 1'b1, 5'd9, 32'h9999, 1'b0, '0, '0, 1'b0);
      else if (busy_cycles == 5) step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
      else if (busy_cycles == 20) step(1'b0, 1'b0, '0, '0, 1'b1, 5'd20, 5'd25, 1'b0);
      else idle();
      if (busy_cycles == 20) begin
        vectors++;
        if (rd_data1 !== exp_rd1 || rd_data2 !== exp_rd2) begin
          miscompares++;
          $display("FAIL read_during_clear got %h/%h want %h/%h",
                   rd_data1, rd_data2, exp_rd1, exp_rd2);
        end
      end
    end
    vectors++;
    if (busy_cycles != DEPTH) begin
      miscompares++; $display("FAIL busy_length got %0d want %0d", busy_cycles, DEPTH);
    end
    for (int i = 0; i < DEPTH / 2; i++) begin
      step(1'b0, 1'b0, '0, '0, 1'b1, AW'(i), AW'(i + DEPTH / 2), 1'b0);
      vectors++;
      if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0) begin
        miscompares++;
        $display("FAIL cleared_entry %0d got %h/%h want 0", i, rd_data1, rd_data2);
      end
    end
  endtask

  task automatic test_clear_reset();
    for (int i = 1; i < DEPTH; i++)
      step(1'b0, 1'b1, AW'(i), 32'hC000_0000 + DW'(i), 1'b0, '0, '0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 9; i++) idle();
    step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++; $display("FAIL abort_busy got %b want 0", busy);
    end
    for (int i = 0; i < DEPTH / 2; i++) begin
      step(1'b0, 1'b0, '0, '0, 1'b1, AW'(2 * i), AW'(2 * i + 1), 1'b0);
      vectors++;
      if (rd_data1 !== 32'h0 || rd_data2 !== 32'h0) begin
        miscompares++;
        $display("FAIL abort_entry %0d got %h/%h want 0", 2 * i, rd_data1, rd_data2);
      end
    end
    step(1'b0, 1'b1, 5'd4, 32'h0000_00A5, 1'b0, '0, '0, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b1, 5'd4, 5'd4, 1'b0);
    vectors++;
    if (rd_data1 !== 32'h0000_00A5) begin
      miscompares++; $display("FAIL post_abort_write got %h want %h", rd_data1, 32'h0000_00A5);
    end
  endtask

  task automatic test_random();
    logic          r, we, re, cl;
    logic [AW-1:0] wa, a1, a2;
    logic [DW-1:0] wd;
    for (int n = 0; n < 1500; n++) begin
      r  = ($urandom_range(0, 199) == 0);
      we = ($urandom_range(0, 3) != 0);
      re = ($urandom_range(0, 4) != 0);
      cl = ($urandom_range(0, 59) == 0);
      wa = AW'($urandom);
      wd = $urandom;
      a1 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom);
      a2 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom);
      step(r, we, wa, wd, re, a1, a2, cl);
      vectors++;
      if (rd_data1 !== exp_rd1 || rd_data2 !== exp_rd2 || busy !== exp_busy) begin
        miscompares++;
        $display("FAIL random cycle %0d got %h/%h/%b want %h/%h/%b", n,
                 rd_data1, rd_data2, busy, exp_rd1, exp_rd2, exp_busy);
      end
    end
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd_en = 1'b0; rd_addr1 = '0; rd_addr2 = '0; clr_start = 1'b0;
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
    @(negedge clk);
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_clear();
    test_clear_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
